// File: rtl/if_fetch_redirect_pkg.sv
// Shared pipeline definitions for the fetch stage: state codes, reset PC,
// bus widths and the IF->ID payload layout.
package if_fetch_redirect_pkg;

    localparam logic [1:0] IF_IDLE = 2'd0;
    localparam logic [1:0] IF_REQ  = 2'd1;
    localparam logic [1:0] IF_WAIT = 2'd2;
    localparam logic [1:0] IF_HOLD = 2'd3;

    localparam logic [31:0] IF_RESET_PC = 32'hBFC0_0000;

    localparam int IF_ID_W = 65;
    localparam int EXC_W   = 33;
    localparam int BR_W    = 33;

    typedef struct packed {
        logic        adel;
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_redirect.sv
// Fetch stage: issues instruction requests over a split addr/data handshake,
// holds the fetched word for ID and absorbs WB redirects at any point in a transaction.
module if_fetch_redirect
    import if_fetch_redirect_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [EXC_W-1:0]    exc_bus,
    input  logic                cancel,
    input  logic [BR_W-1:0]     br_bus,
    input  logic                ID_allow_in,
    output logic                inst_req,
    output logic [31:0]         inst_addr,
    input  logic                inst_addr_ok,
    input  logic                inst_data_ok,
    input  logic [31:0]         inst_rdata,
    output logic                IF_valid,
    output logic [IF_ID_W-1:0]  IF_ID_bus,
    output logic [31:0]         IF_pc
);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_discard;
    logic        r_pend_v;
    logic [31:0] r_pend_pc;
    logic [31:0] r_inst_buf;
    logic        r_adel;

    logic        w_exc_valid;
    logic [31:0] w_exc_pc;
    logic        w_br_taken;
    logic [31:0] w_br_target;
    logic        w_aligned;
    logic        w_hold;
    if_id_t      w_bus;

    assign w_exc_valid = exc_bus[32];
    assign w_exc_pc    = exc_bus[31:0];
    assign w_br_taken  = br_bus[32];
    assign w_br_target = br_bus[31:0];
    assign w_aligned   = (r_pc[1:0] == 2'b00);
    assign w_hold      = (r_state == IF_HOLD);

    assign inst_req  = (r_state == IF_REQ) & w_aligned;
    assign inst_addr = inst_req ? r_pc : 32'h0;
    assign IF_valid  = w_hold & ~cancel & ~w_exc_valid;
    assign IF_pc     = r_pc;

    assign w_bus.adel = r_adel;
    assign w_bus.pc   = r_pc;
    assign w_bus.inst = r_inst_buf;
    assign IF_ID_bus  = w_hold ? w_bus : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IF_IDLE;
            r_pc       <= RESET_PC;
            r_discard  <= 1'b0;
            r_pend_v   <= 1'b0;
            r_pend_pc  <= 32'h0;
            r_inst_buf <= 32'h0;
            r_adel     <= 1'b0;
        end else begin
            case (r_state)
                IF_IDLE: begin
                    r_state <= IF_REQ;
                    if (w_exc_valid) r_pc <= w_exc_pc;
                end
                IF_REQ: begin
                    if (!w_aligned) begin
                        // No bus traffic yet, so a redirect can be taken directly.
                        if (w_exc_valid) begin
                            r_pc     <= w_exc_pc;
                            r_pend_v <= 1'b0;
                        end else if (r_pend_v) begin
                            r_pc     <= r_pend_pc;
                            r_pend_v <= 1'b0;
                        end else begin
                            r_adel     <= 1'b1;
                            r_inst_buf <= 32'h0;
                            r_state    <= IF_HOLD;
                        end
                    end else begin
                        // The address must stay put until accepted; park the redirect.
                        if (w_exc_valid) begin
                            r_pend_v  <= 1'b1;
                            r_pend_pc <= w_exc_pc;
                        end
                        if (inst_addr_ok) begin
                            r_state <= IF_WAIT;
                            if (w_exc_valid || r_pend_v) r_discard <= 1'b1;
                        end
                    end
                end
                IF_WAIT: begin
                    if (inst_data_ok) begin
                        r_discard <= 1'b0;
                        if (w_exc_valid) begin
                            r_pc     <= w_exc_pc;
                            r_pend_v <= 1'b0;
                            r_state  <= IF_REQ;
                        end else if (r_discard) begin
                            r_pc     <= r_pend_pc;
                            r_pend_v <= 1'b0;
                            r_state  <= IF_REQ;
                        end else begin
                            r_inst_buf <= inst_rdata;
                            r_adel     <= 1'b0;
                            r_state    <= IF_HOLD;
                        end
                    end else if (w_exc_valid) begin
                        r_discard <= 1'b1;
                        r_pend_v  <= 1'b1;
                        r_pend_pc <= w_exc_pc;
                    end
                end
                IF_HOLD: begin
                    if (w_exc_valid) begin
                        r_pc    <= w_exc_pc;
                        r_state <= IF_REQ;
                    end else if (cancel) begin
                        r_state <= IF_REQ;
                    end else if (ID_allow_in) begin
                        // Branch resolved in ID applies to the instruction after the delay slot.
                        r_pc    <= w_br_taken ? w_br_target : pc_inc(r_pc);
                        r_state <= IF_REQ;
                    end
                end
                default: r_state <= IF_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_redirect.sv
// Bench for if_fetch_redirect: directed scenarios plus a randomized run checked
// against an architectural PC-stream model and a one-outstanding memory model.
module tb_if_fetch_redirect;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk;
    logic        resetn;
    logic [32:0] exc_bus;
    logic        cancel;
    logic [32:0] br_bus;
    logic        ID_allow_in;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        IF_valid;
    logic [64:0] IF_ID_bus;
    logic [31:0] IF_pc;

    int vectors;
    int miscompares;

    // memory model state
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          mem_lat;
    int          addr_block;
    bit          rand_mode;
    int          cyc;

    if_fetch_redirect dut (
        .clk          (clk),
        .resetn       (resetn),
        .exc_bus      (exc_bus),
        .cancel       (cancel),
        .br_bus       (br_bus),
        .ID_allow_in  (ID_allow_in),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .IF_valid     (IF_valid),
        .IF_ID_bus    (IF_ID_bus),
        .IF_pc        (IF_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Advance one clock; memory answers after mem_lat cycles, one request outstanding.
    task automatic tick();
        logic        acc;
        logic        dok;
        logic [31:0] a;
        acc = inst_req && inst_addr_ok;
        a   = inst_addr;
        dok = inst_data_ok;
        @(posedge clk);
        #1;
        if (!resetn) begin
            mem_busy = 1'b0;
        end else begin
            if (dok) mem_busy = 1'b0;
            if (acc) begin
                if (rand_mode) mem_lat = $urandom_range(1, 3);
                mem_busy = 1'b1;
                mem_addr = a;
                mem_cnt  = mem_lat;
            end
        end
        if (addr_block > 0) addr_block--;
        if (mem_busy) mem_cnt--;
        inst_data_ok = mem_busy && (mem_cnt == 0);
        inst_rdata   = inst_data_ok ? mem_word(mem_addr) : 32'h0;
        inst_addr_ok = !mem_busy && (addr_block == 0) &&
                       (!rand_mode || ($urandom_range(0, 9) < 6));
        cyc++;
        #1;
    endtask

    task automatic wait_accept(output bit ok, output logic [31:0] a);
        ok = 1'b0;
        a  = 32'h0;
        for (int i = 0; i < 40; i++) begin
            if (inst_req && inst_addr_ok) begin
                ok = 1'b1;
                a  = inst_addr;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (IF_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; exc_bus = '0; cancel = 1'b0; br_bus = '0; ID_allow_in = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
        mem_busy = 1'b0; mem_lat = 1; addr_block = 0; rand_mode = 1'b0; cyc = 0;
        tick(); tick();
        vectors++;
        if (inst_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b expected 0", inst_req); end
        vectors++;
        if (IF_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", IF_valid); end
        vectors++;
        if (IF_ID_bus !== 65'h0) begin miscompares++; $display("FAIL reset_bus: got %h expected 0", IF_ID_bus); end
        vectors++;
        if (IF_pc !== RESET_PC) begin miscompares++; $display("FAIL reset_pc: got %h expected %h", IF_pc, RESET_PC); end
        resetn = 1'b1;
        #1;
        vectors++;
        if (inst_req !== 1'b0) begin miscompares++; $display("FAIL idle_req: got %b expected 0", inst_req); end
        tick();
        $display("reset: done, cycle %0d", cyc);
    endtask

    task automatic test_zero_wait();
        bit ok; logic [31:0] a;
        ID_allow_in = 1'b1; mem_lat = 1;
        wait_accept(ok, a);
        vectors++;
        if (!ok || a !== RESET_PC) begin miscompares++; $display("FAIL first_addr: got %h expected %h", a, RESET_PC); end
        tick(); tick();
        vectors++;
        if (IF_valid !== 1'b1 || IF_ID_bus !== {1'b0, RESET_PC, mem_word(RESET_PC)}) begin
            miscompares++; $display("FAIL first_inst: got valid=%b bus=%h expected valid=1 bus=%h",
                IF_valid, IF_ID_bus, {1'b0, RESET_PC, mem_word(RESET_PC)});
        end
        tick();
        vectors++;
        if (IF_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== RESET_PC + 32'd4) begin
            miscompares++; $display("FAIL second_addr: got valid=%b req=%b addr=%h expected 0/1/%h",
                IF_valid, inst_req, inst_addr, RESET_PC + 32'd4);
        end
        tick(); tick();
        vectors++;
        if (IF_valid !== 1'b1 || IF_ID_bus[63:32] !== RESET_PC + 32'd4) begin
            miscompares++; $display("FAIL third_cycle_valid: got valid=%b pc=%h expected 1/%h",
                IF_valid, IF_ID_bus[63:32], RESET_PC + 32'd4);
        end
        ID_allow_in = 1'b0;
        $display("zero_wait: two fetches, cycle %0d", cyc);
    endtask

    task automatic test_branch();
        bit ok; logic [31:0] a;
        wait_valid(ok);
        br_bus = {1'b1, 32'h8000_1000}; ID_allow_in = 1'b1;
        tick();
        ID_allow_in = 1'b0; br_bus = '0;
        wait_accept(ok, a);
        vectors++;
        if (!ok || a !== 32'h8000_1000) begin miscompares++; $display("FAIL br_taken: got %h expected 80001000", a); end
        wait_valid(ok);
        br_bus = {1'b0, 32'h1234_5678}; ID_allow_in = 1'b1;
        tick();
        ID_allow_in = 1'b0; br_bus = '0;
        wait_accept(ok, a);
        vectors++;
        if (!ok || a !== 32'h8000_1004) begin miscompares++; $display("FAIL br_not_taken: got %h expected 80001004", a); end
        $display("branch: taken and not-taken, cycle %0d", cyc);
    endtask

    task automatic test_cancel();
        bit ok; logic [31:0] a;
        wait_valid(ok);
        cancel = 1'b1; ID_allow_in = 1'b1;
        #1;
        vectors++;
        if (IF_valid !== 1'b0) begin miscompares++; $display("FAIL cancel_valid: got %b expected 0", IF_valid); end
        tick();
        cancel = 1'b0; ID_allow_in = 1'b0;
        wait_accept(ok, a);
        vectors++;
        if (!ok || a !== 32'h8000_1004) begin miscompares++; $display("FAIL cancel_refetch: got %h expected 80001004", a); end
        $display("cancel: refetch same pc, cycle %0d", cyc);
    endtask

    task automatic test_exc_wait();
        bit ok; bit seen; logic [31:0] a;
        mem_lat = 3;
        tick();
        exc_bus = {1'b1, 32'h8000_0180};
        tick();
        exc_bus = '0; ID_allow_in = 1'b1;
        seen = 1'b0; ok = 1'b0; a = 32'h0;
        for (int i = 0; i < 20; i++) begin
            if (IF_valid) seen = 1'b1;
            if (inst_req && inst_addr_ok) begin ok = 1'b1; a = inst_addr; break; end
            tick();
        end
        vectors++;
        if (seen) begin miscompares++; $display("FAIL exc_wait_stale: got IF_valid=1 expected 0"); end
        vectors++;
        if (!ok || a !== 32'h8000_0180) begin miscompares++; $display("FAIL exc_wait_addr: got %h expected 80000180", a); end
        mem_lat = 1;
        wait_valid(ok);
        vectors++;
        if (!ok || IF_ID_bus !== {1'b0, 32'h8000_0180, mem_word(32'h8000_0180)}) begin
            miscompares++; $display("FAIL exc_wait_inst: got %h expected %h",
                IF_ID_bus, {1'b0, 32'h8000_0180, mem_word(32'h8000_0180)});
        end
        ID_allow_in = 1'b0;
        $display("exc_wait: stale response dropped, cycle %0d", cyc);
    endtask

    task automatic test_two_exc();
        bit ok; bit seen; int bad; logic [31:0] a;
        addr_block = 5; inst_addr_ok = 1'b0; ID_allow_in = 1'b1;
        tick();
        ID_allow_in = 1'b0;
        vectors++;
        if (inst_req !== 1'b1 || inst_addr !== 32'h8000_0184) begin
            miscompares++; $display("FAIL two_exc_start: got req=%b addr=%h expected 1/80000184", inst_req, inst_addr);
        end
        exc_bus = {1'b1, 32'h8000_0180};
        tick();
        exc_bus = {1'b1, 32'h8000_0200};
        tick();
        exc_bus = '0;
        bad = 0; seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (inst_req !== 1'b1 || inst_addr !== 32'h8000_0184) bad++;
            if (inst_addr_ok) break;
            tick();
        end
        vectors++;
        if (bad != 0 || inst_addr_ok !== 1'b1) begin
            miscompares++; $display("FAIL two_exc_stable: got %0d unstable cycles, addr_ok=%b expected 0/1", bad, inst_addr_ok);
        end
        tick();
        ok = 1'b0; a = 32'h0;
        for (int i = 0; i < 20; i++) begin
            if (IF_valid) seen = 1'b1;
            if (inst_req && inst_addr_ok) begin ok = 1'b1; a = inst_addr; break; end
            tick();
        end
        vectors++;
        if (seen) begin miscompares++; $display("FAIL two_exc_stale: got IF_valid=1 expected 0"); end
        vectors++;
        if (!ok || a !== 32'h8000_0200) begin miscompares++; $display("FAIL two_exc_addr: got %h expected 80000200", a); end
        $display("two_exc: last redirect wins, cycle %0d", cyc);
    endtask

    task automatic test_misaligned();
        bit ok; logic [31:0] a;
        wait_valid(ok);
        br_bus = {1'b1, 32'h8000_0002}; ID_allow_in = 1'b1;
        tick();
        ID_allow_in = 1'b0; br_bus = '0;
        vectors++;
        if (inst_req !== 1'b0) begin miscompares++; $display("FAIL adel_req: got %b expected 0", inst_req); end
        tick();
        vectors++;
        if (IF_valid !== 1'b1 || IF_ID_bus !== {1'b1, 32'h8000_0002, 32'h0}) begin
            miscompares++; $display("FAIL adel_bus: got valid=%b bus=%h expected 1/%h",
                IF_valid, IF_ID_bus, {1'b1, 32'h8000_0002, 32'h0});
        end
        br_bus = {1'b1, 32'h8000_0010}; ID_allow_in = 1'b1;
        tick();
        ID_allow_in = 1'b0; br_bus = '0;
        wait_accept(ok, a);
        vectors++;
        if (!ok || a !== 32'h8000_0010) begin miscompares++; $display("FAIL adel_recover: got %h expected 80000010", a); end
        $display("misaligned: adel delivered, cycle %0d", cyc);
    endtask

    task automatic test_wrap();
        bit ok; logic [31:0] a;
        wait_valid(ok);
        br_bus = {1'b1, 32'hFFFF_FFFC}; ID_allow_in = 1'b1;
        tick();
        ID_allow_in = 1'b0; br_bus = '0;
        wait_valid(ok);
        vectors++;
        if (!ok || IF_ID_bus[63:32] !== 32'hFFFF_FFFC) begin
            miscompares++; $display("FAIL wrap_pc: got %h expected fffffffc", IF_ID_bus[63:32]);
        end
        ID_allow_in = 1'b1;
        tick();
        ID_allow_in = 1'b0;
        wait_accept(ok, a);
        vectors++;
        if (!ok || a !== 32'h0000_0000) begin miscompares++; $display("FAIL wrap_addr: got %h expected 00000000", a); end
        $display("wrap: pc+4 wraps to zero, cycle %0d", cyc);
    endtask

    task automatic test_reset_mid();
        bit ok; logic [31:0] a;
        wait_accept(ok, a);
        mem_lat = 3;
        tick();
        #1;
        resetn = 1'b0;
        #1;
        vectors++;
        if (inst_req !== 1'b0 || IF_valid !== 1'b0 || IF_ID_bus !== 65'h0 || IF_pc !== RESET_PC) begin
            miscompares++; $display("FAIL async_reset: got req=%b valid=%b bus=%h pc=%h expected 0/0/0/%h",
                inst_req, IF_valid, IF_ID_bus, IF_pc, RESET_PC);
        end
        tick();
        resetn = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
        #1;
        vectors++;
        if (IF_valid !== 1'b0 || inst_req !== 1'b0) begin
            miscompares++; $display("FAIL late_data: got valid=%b req=%b expected 0/0", IF_valid, inst_req);
        end
        tick();
        vectors++;
        if (inst_req !== 1'b1 || inst_addr !== RESET_PC) begin
            miscompares++; $display("FAIL restart_addr: got req=%b addr=%h expected 1/%h", inst_req, inst_addr, RESET_PC);
        end
        mem_lat = 1;
        wait_valid(ok);
        vectors++;
        if (!ok || IF_ID_bus !== {1'b0, RESET_PC, mem_word(RESET_PC)}) begin
            miscompares++; $display("FAIL restart_inst: got %h expected %h", IF_ID_bus, {1'b0, RESET_PC, mem_word(RESET_PC)});
        end
        $display("reset_mid: restart from reset pc, cycle %0d", cyc);
    endtask

    // Architectural model: every instruction handed to ID must be the next one in
    // program order (redirects and branches applied), carrying the memory word at its pc.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        logic [31:0] tgt;
        logic [64:0] exp_bus;
        logic        exp_adel;
        bit          prev_stall;
        int          idle_cnt;
        int          delivered;
        exp_pc = RESET_PC; prev_stall = 1'b0; prev_addr = 32'h0; idle_cnt = 0; delivered = 0;
        rand_mode = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            ID_allow_in = ($urandom_range(0, 9) < 7);
            cancel      = ($urandom_range(0, 31) == 0);
            exc_bus     = ($urandom_range(0, 31) == 0) ?
                          {1'b1, 32'h8000_0000 | ($urandom() & 32'h0000_0FFC)} : 33'h0;
            tgt         = 32'h8001_0000 | ($urandom() & 32'h0000_FFFC) |
                          (($urandom_range(0, 15) == 0) ? 32'h2 : 32'h0);
            br_bus      = {($urandom_range(0, 3) == 0), tgt};
            #1;
            if (prev_stall) begin
                vectors++;
                if (inst_req !== 1'b1 || inst_addr !== prev_addr) begin
                    miscompares++; $display("FAIL rnd_addr_stable: got req=%b addr=%h expected 1/%h",
                        inst_req, inst_addr, prev_addr);
                end
            end
            if (cancel || exc_bus[32]) begin
                vectors++;
                if (IF_valid !== 1'b0) begin miscompares++; $display("FAIL rnd_kill: got IF_valid=1 expected 0"); end
            end
            if (mem_busy) begin
                vectors++;
                if (inst_req !== 1'b0) begin miscompares++; $display("FAIL rnd_outstanding: got inst_req=1 expected 0"); end
            end
            idle_cnt++;
            if (IF_valid && ID_allow_in) begin
                exp_adel = (exp_pc[1:0] != 2'b00);
                exp_bus  = {exp_adel, exp_pc, exp_adel ? 32'h0 : mem_word(exp_pc)};
                vectors++;
                if (IF_ID_bus !== exp_bus) begin
                    miscompares++; $display("FAIL rnd_inst: got %h expected %h", IF_ID_bus, exp_bus);
                end
                $display("rnd: delivered pc=%h adel=%b at cycle %0d", IF_ID_bus[63:32], IF_ID_bus[64], cyc);
                exp_pc = br_bus[32] ? br_bus[31:0] : exp_pc + 32'd4;
                delivered++;
                idle_cnt = 0;
            end
            if (exc_bus[32]) exp_pc = exc_bus[31:0];
            if (idle_cnt == 400) begin
                vectors++; miscompares++;
                $display("FAIL rnd_liveness: got no delivery for %0d cycles expected fewer", idle_cnt);
                idle_cnt = 0;
            end
            prev_stall = inst_req && !inst_addr_ok;
            prev_addr  = inst_addr;
            tick();
        end
        exc_bus = '0; cancel = 1'b0; br_bus = '0; ID_allow_in = 1'b0; rand_mode = 1'b0;
        vectors++;
        if (delivered < 100) begin miscompares++; $display("FAIL rnd_count: got %0d deliveries expected >= 100", delivered); end
        $display("random: %0d instructions delivered", delivered);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_zero_wait();
        test_branch();
        test_cancel();
        test_exc_wait();
        test_two_exc();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
